// File: rtl/calc_pkg.sv
// Shared types and constants for the binary-to-BCD result encoder.
//   enc_state_t : encoder FSM states
//   DIGIT_W     : bits per BCD digit / stream token
//   MINUS_CODE  : stream token that stands for the minus sign
package calc_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] MINUS_CODE = 4'hA;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    FINISH,
    STREAM
  } enc_state_t;

endpackage

// File: rtl/bcd_result_encoder_if.sv
// Request/result/stream bundle between the calculator core, the encoder and
// the display driver.
//   start, value        : conversion request (value sampled when accepted)
//   ready, done         : encoder idle / one-cycle result-valid pulse
//   negative, digits,   : registered result (BCD magnitude, units in [3:0])
//   ndigits             :   and its significant digit count
//   dig_valid, dig_data,: token stream to the display, MS token first
//   dig_last, dig_ready
// master: the side that issues requests and consumes tokens.
// slave : the encoder.
interface bcd_result_encoder_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NDIG  = 5
);
  import calc_pkg::*;

  logic                    start;
  logic [WIDTH-1:0]        value;
  logic                    ready;
  logic                    done;
  logic                    negative;
  logic [DIGIT_W*NDIG-1:0] digits;
  logic [2:0]              ndigits;
  logic                    dig_valid;
  logic [DIGIT_W-1:0]      dig_data;
  logic                    dig_last;
  logic                    dig_ready;

  modport master (
    output start, value, dig_ready,
    input  ready, done, negative, digits, ndigits,
           dig_valid, dig_data, dig_last
  );

  modport slave (
    input  start, value, dig_ready,
    output ready, done, negative, digits, ndigits,
           dig_valid, dig_data, dig_last
  );

endinterface

// File: rtl/dabble_step.sv
// One double-dabble iteration, purely combinational.
//   scratch_i : current BCD scratch, NDIG nibbles
//   bit_i     : next magnitude bit (MS first) to shift into the units nibble
//   scratch_o : scratch after add-3 on every nibble >= 5, then shift left 1
module dabble_step
  import calc_pkg::*;
#(
  parameter int unsigned NDIG = 5
) (
  input  logic [DIGIT_W*NDIG-1:0] scratch_i,
  input  logic                    bit_i,
  output logic [DIGIT_W*NDIG-1:0] scratch_o
);

  localparam int unsigned SCR_W = DIGIT_W * NDIG;

  logic [SCR_W-1:0] adj_c;

  // Pre-correct each nibble so the shift that follows carries into the next digit.
  always_comb begin
    adj_c = scratch_i;
    for (int k = 0; k < int'(NDIG); k++) begin
      if (scratch_i[k*DIGIT_W +: DIGIT_W] >= DIGIT_W'(5)) begin
        adj_c[k*DIGIT_W +: DIGIT_W] = scratch_i[k*DIGIT_W +: DIGIT_W] + DIGIT_W'(3);
      end
    end
  end

  assign scratch_o = {adj_c[SCR_W-2:0], bit_i};

endmodule

// File: rtl/bcd_result_encoder.sv
// Converts a signed binary calculator result into BCD display digits with a
// sequential double-dabble (one step per clock), then streams the sign and the
// significant digits, most significant first, to the display driver.
//   clk : rising-edge clock
//   RST : asynchronous, active-high reset
//   bus : bcd_result_encoder_if slave port (request, result, token stream)
module bcd_result_encoder
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NDIG  = 5
) (
  input  logic                 clk,
  input  logic                 RST,
  bcd_result_encoder_if.slave  bus
);

  localparam int unsigned SCR_W = DIGIT_W * NDIG;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned IDX_W = $clog2(NDIG + 1);
  localparam int unsigned ND_W  = 3;

  // Control state
  enc_state_t         state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [WIDTH-1:0]   mag_q,       mag_d;
  logic [SCR_W-1:0]   scratch_q,   scratch_d;
  logic               sign_q,      sign_d;
  logic [IDX_W-1:0]   tok_q,       tok_d;

  // Registered outputs
  logic               ready_q,     ready_d;
  logic               done_q,      done_d;
  logic               negative_q,  negative_d;
  logic [SCR_W-1:0]   digits_q,    digits_d;
  logic [ND_W-1:0]    ndigits_q,   ndigits_d;
  logic               dig_valid_q, dig_valid_d;
  logic [DIGIT_W-1:0] dig_data_q,  dig_data_d;
  logic               dig_last_q,  dig_last_d;

  logic [SCR_W-1:0]   step_c;
  logic [ND_W-1:0]    nd_fin_c;

  // Significant digit count: highest nonzero nibble index + 1, never below 1.
  function automatic logic [ND_W-1:0] sig_digits(input logic [SCR_W-1:0] v);
    sig_digits = ND_W'(1);
    for (int k = 1; k < int'(NDIG); k++) begin
      if (v[k*DIGIT_W +: DIGIT_W] != '0) begin
        sig_digits = ND_W'(k + 1);
      end
    end
  endfunction

  // Nibble select by token index (index == digit position, 0 = units).
  function automatic logic [DIGIT_W-1:0] pick(input logic [SCR_W-1:0] v,
                                               input logic [IDX_W-1:0] i);
    pick = '0;
    for (int k = 0; k < int'(NDIG); k++) begin
      if (IDX_W'(k) == i) begin
        pick = v[k*DIGIT_W +: DIGIT_W];
      end
    end
  endfunction

  dabble_step #(
    .NDIG (NDIG)
  ) u_step (
    .scratch_i (scratch_q),
    .bit_i     (mag_q[WIDTH-1]),
    .scratch_o (step_c)
  );

  assign nd_fin_c = sig_digits(scratch_q);

  // Next-state and next-output logic.
  // Token index: the sign slot sits at index ndigits, digits below it, so the
  // index doubles as the nibble position and the units digit is index 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    scratch_d   = scratch_q;
    sign_d      = sign_q;
    tok_d       = tok_q;
    done_d      = 1'b0;
    negative_d  = negative_q;
    digits_d    = digits_q;
    ndigits_d   = ndigits_q;
    dig_valid_d = dig_valid_q;
    dig_data_d  = dig_data_q;
    dig_last_d  = dig_last_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start && ready_q) begin
          sign_d    = bus.value[WIDTH-1];
          // Two's complement negate; the most negative value maps to 2**(WIDTH-1).
          mag_d     = bus.value[WIDTH-1] ? (~bus.value + WIDTH'(1)) : bus.value;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = CONVERT;
        end
      end

      CONVERT: begin
        scratch_d = step_c;
        mag_d     = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        digits_d    = scratch_q;
        negative_d  = sign_q;
        ndigits_d   = nd_fin_c;
        done_d      = 1'b1;
        dig_valid_d = 1'b1;
        if (sign_q) begin
          tok_d      = IDX_W'(nd_fin_c);
          dig_data_d = MINUS_CODE;
          dig_last_d = 1'b0;
        end else begin
          tok_d      = IDX_W'(nd_fin_c - ND_W'(1));
          dig_data_d = pick(scratch_q, IDX_W'(nd_fin_c - ND_W'(1)));
          dig_last_d = (nd_fin_c == ND_W'(1));
        end
        state_d = STREAM;
      end

      STREAM: begin
        if (dig_valid_q && bus.dig_ready) begin
          if (dig_last_q) begin
            dig_valid_d = 1'b0;
            dig_data_d  = '0;
            dig_last_d  = 1'b0;
            state_d     = IDLE;
          end else begin
            tok_d      = tok_q - IDX_W'(1);
            dig_data_d = pick(digits_q, tok_q - IDX_W'(1));
            dig_last_d = (tok_q == IDX_W'(1));
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mag_q       <= '0;
      scratch_q   <= '0;
      sign_q      <= 1'b0;
      tok_q       <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      negative_q  <= 1'b0;
      digits_q    <= '0;
      ndigits_q   <= ND_W'(1);
      dig_valid_q <= 1'b0;
      dig_data_q  <= '0;
      dig_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      scratch_q   <= scratch_d;
      sign_q      <= sign_d;
      tok_q       <= tok_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      negative_q  <= negative_d;
      digits_q    <= digits_d;
      ndigits_q   <= ndigits_d;
      dig_valid_q <= dig_valid_d;
      dig_data_q  <= dig_data_d;
      dig_last_q  <= dig_last_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.negative  = negative_q;
  assign bus.digits    = digits_q;
  assign bus.ndigits   = ndigits_q;
  assign bus.dig_valid = dig_valid_q;
  assign bus.dig_data  = dig_data_q;
  assign bus.dig_last  = dig_last_q;

endmodule

// File: tb/tb_bcd_result_encoder.sv
// Bench for bcd_result_encoder: a decimal-arithmetic reference model predicts
// result registers, done timing and the token stream; a negedge monitor checks
// the DUT every cycle, and directed jobs pin the model with literal values.
module tb_bcd_result_encoder;

  logic clk;
  logic RST;

  bcd_result_encoder_if #(.WIDTH(16), .NDIG(5)) bus ();

  bcd_result_encoder #(.WIDTH(16), .NDIG(5)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mode  = 0;   // dig_ready: 0 = always 1, 1 = random, 2 = held low

  // Reference model state (written only by the monitor).
  logic [3:0]  exp_q [$];
  logic        busy      = 1'b0;
  logic        streaming = 1'b0;
  int          done_due  = -1;
  int          acc_cyc   = 0;
  int          done_cyc  = 0;
  logic        pend_neg;
  logic [19:0] pend_dg;
  logic [2:0]  pend_nd;
  logic        held_neg  = 1'b0;
  logic [19:0] held_dg   = '0;
  logic [2:0]  held_nd   = 3'd1;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [3:0]  prev_data  = '0;
  logic        prev_last  = 1'b0;
  logic [3:0]  got_q [$];
  logic        got_l [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Decimal reference: sign, BCD magnitude and significant digit count.
  task automatic model(input logic [15:0] v, output logic neg,
                       output logic [19:0] dg, output logic [2:0] nd);
    int m;
    m   = int'($signed(v));
    neg = (m < 0);
    if (neg) m = -m;
    dg = '0;
    nd = 3'd1;
    for (int k = 0; k < 5; k++) begin
      dg[k*4 +: 4] = 4'(m % 10);
      if ((m % 10) != 0) nd = 3'(k + 1);
      m = m / 10;
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    bus.dig_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       bus.dig_ready = 1'b1;
        1:       bus.dig_ready = 1'($urandom_range(0, 1));
        default: bus.dig_ready = 1'b0;
      endcase
    end
  end

  // Per-cycle monitor against the reference model.
  always @(negedge clk) begin
    logic [3:0] t;
    if (RST) begin
      chk("rst_ready",     32'(bus.ready),     32'd1);
      chk("rst_done",      32'(bus.done),      32'd0);
      chk("rst_negative",  32'(bus.negative),  32'd0);
      chk("rst_digits",    32'(bus.digits),    32'd0);
      chk("rst_ndigits",   32'(bus.ndigits),   32'd1);
      chk("rst_dig_valid", 32'(bus.dig_valid), 32'd0);
      chk("rst_dig_data",  32'(bus.dig_data),  32'd0);
      chk("rst_dig_last",  32'(bus.dig_last),  32'd0);
      exp_q.delete();
      busy = 0; streaming = 0; done_due = -1;
      held_neg = 0; held_dg = '0; held_nd = 3'd1;
      prev_valid = 0; prev_ready = 0;
    end else begin
      chk("ready", 32'(bus.ready), 32'(!busy));
      chk("done",  32'(bus.done),  32'(cyc == done_due));
      if (cyc == done_due) begin
        held_neg = pend_neg; held_dg = pend_dg; held_nd = pend_nd;
        done_cyc = cyc;
        streaming = 1'b1;
      end
      chk("digits",   32'(bus.digits),   32'(held_dg));
      chk("negative", 32'(bus.negative), 32'(held_neg));
      chk("ndigits",  32'(bus.ndigits),  32'(held_nd));
      chk("dig_valid", 32'(bus.dig_valid), 32'(streaming));
      if (prev_valid && !prev_ready) begin
        chk("stall_data", 32'(bus.dig_data), 32'(prev_data));
        chk("stall_last", 32'(bus.dig_last), 32'(prev_last));
      end
      if (streaming && bus.dig_valid && bus.dig_ready) begin
        t = exp_q.pop_front();
        chk("token", 32'(bus.dig_data), 32'(t));
        chk("token_last", 32'(bus.dig_last), 32'(exp_q.size() == 0));
        got_q.push_back(bus.dig_data);
        got_l.push_back(bus.dig_last);
        if (exp_q.size() == 0) begin
          busy = 1'b0;
          streaming = 1'b0;
        end
      end
      prev_valid = bus.dig_valid;
      prev_ready = bus.dig_ready;
      prev_data  = bus.dig_data;
      prev_last  = bus.dig_last;
      if (bus.start && !busy) begin
        model(bus.value, pend_neg, pend_dg, pend_nd);
        exp_q.delete();
        if (pend_neg) exp_q.push_back(4'hA);
        for (int k = int'(pend_nd) - 1; k >= 0; k--) exp_q.push_back(pend_dg[k*4 +: 4]);
        busy = 1'b1;
        done_due = cyc + 18;
        acc_cyc = cyc + 1;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (!busy) break;
    end
    chk("job_finish", 32'(busy), 32'd0);
  endtask

  task automatic pulse_start(input logic [15:0] v);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.value = v;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.value = 16'h5A5A;
  endtask

  // Tokens received since index n0, packed MS first, plus count of last flags.
  task automatic check_log(input string nm, input int n0,
                           input logic [31:0] word, input int n);
    logic [31:0] w = '0;
    int nl = 0;
    for (int i = n0; i < got_q.size(); i++) begin
      w = (w << 4) | 32'(got_q[i]);
      if (got_l[i]) nl++;
    end
    chk({nm, "_tokens"}, w, word);
    chk({nm, "_count"}, 32'(got_q.size() - n0), 32'(n));
    chk({nm, "_lastcnt"}, 32'(nl), 32'd1);
  endtask

  initial begin
    logic        n;
    logic [19:0] d;
    logic [2:0]  c;
    int          n0;

    RST = 1'b1;
    bus.start = 1'b0;
    bus.value = '0;

    // Pin the reference model with hand-computed values.
    model(16'd1234, n, d, c);
    chk("pin_1234_dg", 32'(d), 32'h01234);
    chk("pin_1234_nd", 32'(c), 32'd4);
    model(16'h8000, n, d, c);
    chk("pin_m32768_dg", 32'(d), 32'h32768);
    chk("pin_m32768_neg", 32'(n), 32'd1);
    chk("pin_m32768_nd", 32'(c), 32'd5);
    model(16'd0, n, d, c);
    chk("pin_0_nd", 32'(c), 32'd1);

    repeat (3) @(posedge clk);
    #1 RST = 1'b0;

    // 1234 with a always-ready display.
    n0 = got_q.size();
    pulse_start(16'd1234);
    wait_idle();
    chk("lat_1234", 32'(done_cyc - acc_cyc), 32'd17);
    chk("digits_1234", 32'(bus.digits), 32'h01234);
    check_log("v1234", n0, 32'h1234, 4);

    // Most negative value.
    n0 = got_q.size();
    pulse_start(16'h8000);
    wait_idle();
    chk("neg_m32768", 32'(bus.negative), 32'd1);
    check_log("vm32768", n0, 32'hA32768, 6);

    // Zero.
    n0 = got_q.size();
    pulse_start(16'd0);
    wait_idle();
    check_log("v0", n0, 32'h0, 1);

    // -7 with a randomly stalling display.
    mode = 1;
    n0 = got_q.size();
    pulse_start(16'hFFF9);
    wait_idle();
    check_log("vm7", n0, 32'hA7, 2);
    mode = 0;

    // Starts during CONVERT and STREAM are ignored.
    n0 = got_q.size();
    pulse_start(16'd500);
    repeat (4) @(posedge clk);
    pulse_start(16'd777);
    mode = 2;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (streaming) break;
    end
    chk("reach_stream", 32'(streaming), 32'd1);
    pulse_start(16'd888);
    repeat (3) @(posedge clk);
    mode = 0;
    wait_idle();
    check_log("v500", n0, 32'h500, 3);

    // Reset during conversion, then a fresh job.
    pulse_start(16'd4321);
    repeat (7) @(posedge clk);
    #1 RST = 1'b1;
    repeat (2) @(posedge clk);
    #1 RST = 1'b0;
    n0 = got_q.size();
    pulse_start(16'd99);
    wait_idle();
    check_log("v99", n0, 32'h99, 2);

    // Random spot values through the model.
    mode = 1;
    for (int i = 0; i < 6; i++) begin
      pulse_start(16'($urandom));
      wait_idle();
    end
    mode = 0;

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
